alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit implementing the RV32M operations for the execute stage.
//  It sits beside the single-cycle integer ALU and is selected for funct7=0000001 OP instructions.
//  It uses a valid/ready handshake on both the operand side and the result side.
//  Multiply completes in one cycle; divide/remainder uses a restoring shift-subtract divider.
// PARAMETERS
//  XLEN      32   operand/result width in bits; any even value >= 8
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-high
//  flush      in   1     synchronous abort of any in-flight op (pipeline redirect)
//  in_valid   in   1     operands and op are valid
//  in_ready   out  1     unit can accept an op
//  op         in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  src1       in   XLEN  rs1 value (dividend / multiplicand)
//  src2       in   XLEN  rs2 value (divisor / multiplier)
//  out_valid  out  1     result is valid
//  out_ready  in   1     consumer takes the result
//  result     out  XLEN  result, held stable while out_valid=1 and out_ready=0
// BEHAVIOUR
//  - FSM states: IDLE, MUL, DIV, DONE. Reset -> IDLE, out_valid=0, result=0.
//  - in_ready = (state==IDLE). Accept = in_valid & in_ready. Op and operands are latched on accept.
//  - IDLE->MUL on accept with op[2]=0.
//    * MUL: compute the 2*XLEN product of the latched operands.
//    * Operand signedness: MULH s*s, MULHSU s*u, MULHU u*u.
//    * Result: MUL takes the low XLEN bits; the other three take the high XLEN bits.
//    * Write the result; go to DONE. out_valid=1 on cycle T+2, where accept is cycle T.
//  - IDLE->DIV on accept with op[2]=1. Operand checks on entry, in this order:
//    * Divisor==0: quotient=all ones, remainder=src1. Go to DONE next cycle, out_valid at T+2.
//    * Signed (DIV/REM) with src1=most-negative and src2=-1: quotient=src1, remainder=0.
//      Same early exit, out_valid at T+2.
//    * Otherwise: for the signed ops, take the magnitudes. Record the quotient sign (s1^s2)
//      and the remainder sign (s1). Run XLEN iterations, one quotient bit per cycle,
//      MSB first, using an XLEN-bit counter.
//    * After the final iteration, apply the sign fixup and go to DONE. out_valid at T+XLEN+2.
//  - DONE: out_valid=1 and result held. When out_ready=1, go to IDLE next cycle
//    (out_valid=0, in_ready=1). No accept while in DONE: back-to-back ops are 1 bubble apart.
//  - flush=1 (any state): next state IDLE, out_valid=0, counter cleared.
//    flush overrides any accept or output handshake in the same cycle.
//    result register contents are don't-care after a flush.
//  - rst asserted mid-operation: immediate return to reset values; no partial result is emitted.
//  - in_valid while busy is ignored (in_ready=0). Operand changes after accept have no effect.
//  - All arithmetic is modulo 2^XLEN. The signed remainder takes the sign of the dividend
//    (RISC-V semantics).
// TESTING
//  1 MUL 7 * -3 (0x00000007, 0xFFFFFFFD) -> result 0xFFFFFFEB, out_valid 2 cycles after accept.
//  2 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU -> 2;
//    each out_valid at T+XLEN+2 (T+34).
//  4 DIVU x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0;
//    all with out_valid at T+2.
//  5 out_ready low 10 cycles after DONE -> result/out_valid stable, in_ready=0.
//    Release -> in_ready=1 next cycle.
//  6 flush at iteration 5 of DIV, and rst at iteration 10 of another DIV
//    -> no out_valid, in_ready=1 next cycle, next DIVU 9/3 returns 3.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Operand/result handshake bundle for the RV32M multiply/divide unit.
// The master issues ops and consumes results; the slave is the unit itself.
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Multiply takes a single compute cycle; divide/remainder runs a restoring
// shift-subtract divider producing one quotient bit per cycle, MSB first,
// after a one-cycle setup that also catches divide-by-zero and signed overflow.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    alu_muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] cnt_q;
    logic            started_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            is_signed_div;
    logic            is_rem;
    logic            div_zero;
    logic            div_ovf;
    logic            last_iter;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    logic            mul_a_sx;
    logic            mul_b_sx;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0] mul_res;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;

    // Operand classification for the divider; DIV/REM have op bit 0 clear.
    always_comb begin
        is_signed_div = ~op_q[0];
        is_rem        = op_q[1];
        div_zero      = (b_q == '0);
        div_ovf       = is_signed_div && (a_q == MOST_NEG) && (b_q == '1);
        last_iter     = started_q && (cnt_q == XLEN'(XLEN - 1));
        a_abs         = (is_signed_div && a_q[XLEN-1]) ? (-a_q) : a_q;
        b_abs         = (is_signed_div && b_q[XLEN-1]) ? (-b_q) : b_q;
    end

    // Full-width product with per-op sign extension; MUL keeps the low half.
    always_comb begin
        mul_a_sx = ((op_q == 2'd1) || (op_q == 2'd2)) && a_q[XLEN-1];
        mul_b_sx = (op_q == 2'd1) && b_q[XLEN-1];
        mul_a    = {{XLEN{mul_a_sx}}, a_q};
        mul_b    = {{XLEN{mul_b_sx}}, b_q};
        product  = mul_a * mul_b;
        mul_res  = (op_q == 2'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, b_q};
        rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};
        q_fix    = q_neg_q ? (-quo_next) : quo_next;
        r_fix    = r_neg_q ? (-rem_next) : rem_next;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush wins over every other transition.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = bus.op[2] ? DIV : MUL;
                end
            end
            MUL: begin
                state_next = DONE;
            end
            DIV: begin
                if (!started_q && (div_zero || div_ovf)) begin
                    state_next = DONE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Operand latch, divider datapath and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else if (flush) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.op[1:0];
                        a_q       <= bus.src1;
                        b_q       <= bus.src2;
                        cnt_q     <= '0;
                        started_q <= 1'b0;
                    end
                end
                MUL: begin
                    result_q <= mul_res;
                end
                DIV: begin
                    if (!started_q) begin
                        if (div_zero) begin
                            result_q <= is_rem ? a_q : '1;
                        end else if (div_ovf) begin
                            result_q <= is_rem ? '0 : a_q;
                        end else begin
                            quo_q     <= a_abs;
                            b_q       <= b_abs;
                            rem_q     <= '0;
                            q_neg_q   <= is_signed_div && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                            r_neg_q   <= is_signed_div && a_q[XLEN-1];
                            cnt_q     <= '0;
                            started_q <= 1'b1;
                        end
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + XLEN'(1);
                        if (last_iter) begin
                            result_q  <= is_rem ? r_fix : q_fix;
                            started_q <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus randomized ops,
// compared against a plain-arithmetic RV32M reference model.
module tb_alu_muldiv;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    alu_muldiv_if #(.XLEN(XLEN)) bus ();

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int lat;
    logic [31:0] obs_result;

    // RV32M semantics straight from the ISA rules, using wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (op)
            3'd0: r = a * b;
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycle (relative to accept) at which out_valid is expected to rise.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op and hold it until accepted; scramble inputs afterwards.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
    endtask

    // Count cycles until out_valid; lat is the cycle index relative to accept.
    task automatic waitResult();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.out_valid !== 1'b1 && n < 60);
        lat = n + 1;
        obs_result = bus.result;
        if (bus.out_valid !== 1'b1) checkOutput("result_timeout", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        applyStimulus(op, a, b);
        waitResult();
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
        checkOutput(tag, obs_result, ref_model(op, a, b));
        @(posedge clk);
        #1;
        checkOutput({tag, "_pop"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] exp_res;
        logic        saw_valid;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply directed cases
        runOp(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7_m3");
        runOp(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");

        // Divide directed cases
        runOp(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        runOp(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        runOp(3'd5, 32'd100, 32'd7, "divu_100_7");
        runOp(3'd7, 32'd100, 32'd7, "remu_100_7");

        // Early-exit divide cases
        runOp(3'd5, 32'h1234_5678, 32'd0, "divu_x_0");
        runOp(3'd6, 32'd5, 32'd0, "rem_5_0");
        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        // Output back-pressure: result held for 10 cycles, no accept while in DONE
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_res = ref_model(3'd0, 32'd7, 32'hFFFF_FFFD);
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD);
        waitResult();
        checkOutput("stall_first", obs_result, exp_res);
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("stall_hold", bus.result, exp_res);
            checkOutput("stall_flags", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

        // Flush at iteration 5 of a divide
        applyStimulus(3'd4, 32'd1000, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) saw_valid = 1'b1;
        end
        checkOutput("flush_no_valid", {31'd0, saw_valid}, 32'd0);

        // Reset at iteration 10 of a divide
        applyStimulus(3'd4, 32'd5000, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_flags", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        checkOutput("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        runOp(3'd5, 32'd9, 32'd3, "divu_9_3");

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                3: rb = {28'd0, 4'($urandom)};
                default: begin end
            endcase
            runOp(rop, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
